tl_arbiter: RTL
===============

# tl_arbiter

Two-master TileLink-UL arbiter that shares the core's single `tilelink` bus master port between the instruction-fetch stage (m0) and the access stage (m1). It supports one outstanding single-beat transaction at a time, performs round-robin arbitration on channel A, and routes the channel D response back to the master that owns the transaction. It sits between the pipeline stages and the system interconnect, directly upstream of the port the access stage's debug monitor observes.

## Interface
- `RR_INIT`, default 1: index of the master favoured on the first contested grant after reset (1 = access stage).
- `clk` input, 1 bit: clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `m0` `tilelink.slave`: fetch-stage upstream port. Fields: a_valid, a_ready, a_opcode[2:0], a_param[2:0], a_size[2:0], a_address[63:0], a_mask[7:0], a_data[63:0], d_valid, d_ready, d_opcode[2:0], d_param[1:0], d_size[2:0], d_data[63:0].
- `m1` `tilelink.slave`: access-stage upstream port. Same fields as `m0`.
- `bus` `tilelink.master`: downstream port to the interconnect.
- `busy` output, 1 bit: high while state is not IDLE.
- `owner` output, 1 bit: index of the current or last granted master.

## Operation
- FSM with three states:
  - IDLE: no grant held.
  - REQ: grant locked and A beat pending.
  - RESP: A beat accepted, waiting for the D beat.
- Grant selection (combinational, IDLE only):
  - Only one of m0/m1 a_valid is high: grant that master.
  - Both are high: grant `~last`, where `last` is a registered pointer of the last accepted grant, reset to `~RR_INIT`.
- A channel in IDLE:
  - bus.a_* = granted master's a_*.
  - The granted master's a_ready = bus.a_ready; the other master's a_ready = 0.
- A channel in REQ:
  - The same forwarding applies, but with the latched `owner`. The grant must not change while the beat is pending; TileLink requires a_* to stay stable.
- A channel in RESP:
  - bus.a_valid = 0.
  - Both a_ready = 0.
- Transitions out of IDLE:
  - bus.a_valid & bus.a_ready → RESP.
  - bus.a_valid & ~bus.a_ready → REQ.
  - Either way, latch `owner`.
- Transitions out of REQ: a handshake → RESP.
- `last` is updated to `owner` only on an A handshake.
- D channel in RESP:
  - owner.d_* = bus.d_*.
  - bus.d_ready = owner.d_ready.
  - Non-owner d_valid = 0.
- D channel in any other state:
  - bus.d_ready = 0.
  - Both d_valid = 0.
- RESP → IDLE on bus.d_valid & bus.d_ready.
- A D beat arriving while not in RESP is a protocol error: it is not forwarded, and an assertion fires in simulation.
- Reset values:
  - state = IDLE, owner = 0, last = ~RR_INIT, busy = 0.
  - All a_ready, d_valid and bus.a_valid/bus.d_ready = 0.
- Reset mid-transaction: the arbiter returns to IDLE immediately and any in-flight response is dropped. The interconnect is reset by the same rst_n.

## Timing
- The A-channel path is combinational: zero-cycle grant latency in IDLE when bus.a_ready is high.
- Minimum transaction occupancy is 2 cycles: A accept in cycle N, D accept in cycle N+1 at the earliest.
- One idle bubble: after the D handshake in cycle N, a new A beat can be accepted in cycle N+1 at the earliest, because the state returns to IDLE at edge N+1.
- Under continuous contention, grants alternate strictly between m0 and m1.
- A master whose a_valid drops in IDLE before being granted loses nothing. TileLink forbids dropping valid after it has been presented to an un-ready slave, but the arbiter does not rely on that, because the grant locks only via REQ.

## Structure
- The shared package `tl_pkg` holds:
  - the TL opcode constants (Get=4, PutFullData=0, PutPartialData=1, AccessAck=0, AccessAckData=1);
  - the state enum `tl_arb_state_t`.
- Round-robin selection is a natural sub-module, `rr_pick2`: inputs req[1:0] and last; output gnt.
- Debug tracing uses the existing `check_verbose()` guard and is not part of the synthesizable logic.

## Test plan
- **Single master:** m1 Get at address 0x8000_0010, size 3, with bus.a_ready=1 → bus.a_address=0x80000010 the same cycle, state RESP. D AccessAckData data 0xDEADBEEF → m1.d_valid=1 with that data; m0.d_valid=0; busy=0 the next cycle.
- **Contention after reset:** m0 and m1 both valid in the first cycle → m1 granted (RR_INIT=1). After its D beat, m0 is granted. A third contested request is granted to m1.
- **Back-pressure:**
  - m0 valid, bus.a_ready=0 for 3 cycles → state REQ.
  - m1 raising a_valid in cycle 2 does not steal the grant; bus.a_address stays at m0's address until the handshake.
- **D back-pressure:** bus.d_valid=1 with m1.d_ready=0 for 2 cycles → bus.d_ready=0 and the state stays RESP. Then d_ready=1 → IDLE.
- **Reset mid-RESP:** assert rst_n=0 while in RESP → all outputs drop to their reset values asynchronously. After release, the first contested grant goes to m1.
- **Spurious D:** bus.d_valid=1 in IDLE → no master sees d_valid, bus.d_ready=0, and the simulation assertion fires.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions for the core's bus-side blocks:
// opcode constants, beat bundles and the arbiter state encoding.
package tl_pkg;

  // Channel A opcodes
  localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_A_GET         = 3'd4;

  // Channel D opcodes
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  // Arbiter phases: no grant / grant locked with A pending / waiting for D
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } tl_arb_state_t;

  // Channel A payload (everything except the valid/ready pair)
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [63:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
  } tl_a_beat_t;

endpackage

// File: rtl/tl_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes
// to the master that did not win the previous accepted grant.
module rr_pick2
  import tl_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_gnt
);

  // Resolve the winner index from the request pair and the last winner
  always_comb begin
    o_gnt = ~i_last;
    case (i_req)
      2'b01:   o_gnt = 1'b0;
      2'b10:   o_gnt = 1'b1;
      default: o_gnt = ~i_last;
    endcase
  end

endmodule

// File: rtl/tl_arbiter.sv
// Two-master TileLink-UL arbiter: fetch stage (m0) and access stage (m1)
// share one downstream port. One single-beat transaction in flight at a
// time; round-robin on channel A, D routed back to the owning master.
module tl_arbiter
  import tl_pkg::*;
#(
  parameter bit RR_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  // m0: fetch-stage upstream port
  input  logic        i_m0_a_valid,
  output logic        o_m0_a_ready,
  input  logic [2:0]  i_m0_a_opcode,
  input  logic [2:0]  i_m0_a_param,
  input  logic [2:0]  i_m0_a_size,
  input  logic [63:0] i_m0_a_address,
  input  logic [7:0]  i_m0_a_mask,
  input  logic [63:0] i_m0_a_data,
  output logic        o_m0_d_valid,
  input  logic        i_m0_d_ready,
  output logic [2:0]  o_m0_d_opcode,
  output logic [1:0]  o_m0_d_param,
  output logic [2:0]  o_m0_d_size,
  output logic [63:0] o_m0_d_data,
  // m1: access-stage upstream port
  input  logic        i_m1_a_valid,
  output logic        o_m1_a_ready,
  input  logic [2:0]  i_m1_a_opcode,
  input  logic [2:0]  i_m1_a_param,
  input  logic [2:0]  i_m1_a_size,
  input  logic [63:0] i_m1_a_address,
  input  logic [7:0]  i_m1_a_mask,
  input  logic [63:0] i_m1_a_data,
  output logic        o_m1_d_valid,
  input  logic        i_m1_d_ready,
  output logic [2:0]  o_m1_d_opcode,
  output logic [1:0]  o_m1_d_param,
  output logic [2:0]  o_m1_d_size,
  output logic [63:0] o_m1_d_data,
  // bus: downstream port to the interconnect
  output logic        o_bus_a_valid,
  input  logic        i_bus_a_ready,
  output logic [2:0]  o_bus_a_opcode,
  output logic [2:0]  o_bus_a_param,
  output logic [2:0]  o_bus_a_size,
  output logic [63:0] o_bus_a_address,
  output logic [7:0]  o_bus_a_mask,
  output logic [63:0] o_bus_a_data,
  input  logic        i_bus_d_valid,
  output logic        o_bus_d_ready,
  input  logic [2:0]  i_bus_d_opcode,
  input  logic [1:0]  i_bus_d_param,
  input  logic [2:0]  i_bus_d_size,
  input  logic [63:0] i_bus_d_data,
  // status
  output logic        o_busy,
  output logic        o_owner
);

  tl_arb_state_t r_state, w_state_next;
  logic          r_owner, w_owner_next;
  logic          r_last,  w_last_next;

  tl_a_beat_t    w_a_beat [2];
  logic [1:0]    w_a_valid;
  logic [1:0]    w_a_ready;
  logic [1:0]    w_d_ready;
  logic [1:0]    w_d_valid;
  logic          w_rr_gnt;
  logic          w_sel;
  logic          w_a_open;
  logic          w_resp;
  logic          w_a_fire;
  logic          w_d_fire;
  tl_a_beat_t    w_bus_a;

  assign w_a_valid   = {i_m1_a_valid, i_m0_a_valid};
  assign w_d_ready   = {i_m1_d_ready, i_m0_d_ready};
  assign w_a_beat[0] = {i_m0_a_opcode, i_m0_a_param, i_m0_a_size,
                        i_m0_a_address, i_m0_a_mask, i_m0_a_data};
  assign w_a_beat[1] = {i_m1_a_opcode, i_m1_a_param, i_m1_a_size,
                        i_m1_a_address, i_m1_a_mask, i_m1_a_data};

  rr_pick2 u_rr_pick2 (
    .i_req  (w_a_valid),
    .i_last (r_last),
    .o_gnt  (w_rr_gnt)
  );

  // Fresh pick only in IDLE; once locked the owner must not change while
  // the A beat is pending, since a_* has to stay stable until accepted.
  assign w_sel = (r_state == ARB_IDLE) ? w_rr_gnt : r_owner;

  // rst_n gates the forwarding paths so every handshake output drops to
  // its reset value as soon as reset asserts, not at the next edge.
  assign w_a_open = rst_n && (r_state != ARB_RESP);
  assign w_resp   = rst_n && (r_state == ARB_RESP);

  assign o_bus_a_valid   = w_a_open && w_a_valid[w_sel];
  assign w_bus_a         = w_a_beat[w_sel];
  assign o_bus_a_opcode  = w_bus_a.opcode;
  assign o_bus_a_param   = w_bus_a.param;
  assign o_bus_a_size    = w_bus_a.size;
  assign o_bus_a_address = w_bus_a.address;
  assign o_bus_a_mask    = w_bus_a.mask;
  assign o_bus_a_data    = w_bus_a.data;

  assign w_a_fire = o_bus_a_valid && i_bus_a_ready;

  // Per-master ready/valid steering. In IDLE a master only counts as
  // granted while it is actually requesting; in REQ the lock holds.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      assign w_a_ready[gi] = w_a_open && (w_sel == 1'(gi)) && i_bus_a_ready &&
                             ((r_state == ARB_REQ) || w_a_valid[gi]);
      assign w_d_valid[gi] = w_resp && (r_owner == 1'(gi)) && i_bus_d_valid;
    end
  endgenerate

  assign o_bus_d_ready = w_resp && w_d_ready[r_owner];
  assign w_d_fire      = i_bus_d_valid && o_bus_d_ready;

  assign o_m0_a_ready  = w_a_ready[0];
  assign o_m1_a_ready  = w_a_ready[1];
  assign o_m0_d_valid  = w_d_valid[0];
  assign o_m1_d_valid  = w_d_valid[1];

  // D payload is broadcast; only the owner's d_valid qualifies it.
  assign o_m0_d_opcode = i_bus_d_opcode;
  assign o_m0_d_param  = i_bus_d_param;
  assign o_m0_d_size   = i_bus_d_size;
  assign o_m0_d_data   = i_bus_d_data;
  assign o_m1_d_opcode = i_bus_d_opcode;
  assign o_m1_d_param  = i_bus_d_param;
  assign o_m1_d_size   = i_bus_d_size;
  assign o_m1_d_data   = i_bus_d_data;

  assign o_busy  = (r_state != ARB_IDLE);
  assign o_owner = r_owner;

  // Next-state, owner latch and round-robin pointer update
  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_last_next  = r_last;
    case (r_state)
      ARB_IDLE: begin
        if (o_bus_a_valid) begin
          w_owner_next = w_sel;
          w_state_next = i_bus_a_ready ? ARB_RESP : ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (w_a_fire) w_state_next = ARB_RESP;
      end
      ARB_RESP: begin
        if (w_d_fire) w_state_next = ARB_IDLE;
      end
      default: w_state_next = ARB_IDLE;
    endcase
    if (w_a_fire) w_last_next = w_sel;
  end

  // State registers; reset drops any in-flight response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_owner <= 1'b0;
      r_last  <= ~RR_INIT;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_last  <= w_last_next;
    end
  end

  // A D beat outside RESP is never forwarded; flag it in simulation
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(i_bus_d_valid && (r_state != ARB_RESP)))
    else $warning("tl_arbiter: D beat outside RESP dropped");

endmodule
